// File: rtl/snn_inference_ctrl_if.sv
// Handshake and data bundle between the SNN inference controller (slave) and
// the frame source, host and output-neuron array (master).
interface snn_inference_ctrl_if #(
    parameter int NUM_OUT = 10,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = $clog2(NUM_OUT);

    logic               start;
    logic               abort;
    logic               busy;
    logic               nrn_rst;
    logic               frm_vld;
    logic               frm_rdy;
    logic               in_en;
    logic [NUM_OUT-1:0] spk_in;
    logic               res_valid;
    logic               res_ready;
    logic [IDX_W-1:0]   res_idx;
    logic [CNT_W-1:0]   res_cnt;
    logic               res_early;

    modport master (
        output start, abort, frm_vld, spk_in, res_ready,
        input  busy, nrn_rst, frm_rdy, in_en, res_valid, res_idx, res_cnt, res_early
    );

    modport slave (
        input  start, abort, frm_vld, spk_in, res_ready,
        output busy, nrn_rst, frm_rdy, in_en, res_valid, res_idx, res_cnt, res_early
    );
endinterface

// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference: clear neurons, gate NUM_STEPS frames, drain, argmax.
// Define SNN_CTRL_EARLY_EXIT_EN to leave FETCH once any spike count reaches EARLY_THR.
module snn_inference_ctrl #(
    parameter int NUM_OUT   = 10,
    parameter int NUM_STEPS = 16,
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 3,
    parameter int EARLY_THR = 8
) (
    input  logic                clk,
    input  logic                reset,
    snn_inference_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_OUT);
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int DRN_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef SNN_CTRL_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, ARGMAX, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt [NUM_OUT];
    logic [STEP_W-1:0] step_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [IDX_W-1:0]  arg_ptr, best_idx, res_idx_q;
    logic [CNT_W-1:0]  best_cnt, res_cnt_q;
    logic              res_early_q;
    logic              last_step, last_drain, last_arg;
    logic              early_hit, early_exit, arg_gt, count_en;

    assign bus.busy      = (state != IDLE);
    assign bus.nrn_rst   = (state == CLEAR);
    assign bus.frm_rdy   = (state == FETCH);
    assign bus.in_en     = bus.frm_vld && bus.frm_rdy;
    assign bus.res_valid = (state == DONE);
    assign bus.res_idx   = res_idx_q;
    assign bus.res_cnt   = res_cnt_q;
    assign bus.res_early = res_early_q;

    assign count_en   = (state == FETCH) || (state == DRAIN);
    assign last_step  = bus.in_en && (step_cnt == STEP_W'(NUM_STEPS - 1));
    assign last_drain = (drain_cnt == DRN_W'(DRAIN_CYC - 1));
    assign last_arg   = (arg_ptr == IDX_W'(NUM_OUT - 1));
    assign arg_gt     = (cnt[arg_ptr] > best_cnt);
    assign early_exit = EARLY_EN && early_hit;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        early_hit = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(cnt[i]) >= EARLY_THR) early_hit = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = CLEAR;
            CLEAR:   state_nxt = FETCH;
            FETCH:   if (last_step || early_exit) state_nxt = DRAIN;
            DRAIN:   if (last_drain) state_nxt = ARGMAX;
            ARGMAX:  if (last_arg) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the counter array sits under the async reset because the result is read from it;
    // it is a handful of flops, not a RAM, so resetting it costs nothing structural.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
            step_cnt    <= '0;
            drain_cnt   <= '0;
            arg_ptr     <= '0;
            best_idx    <= '0;
            best_cnt    <= '0;
            res_idx_q   <= '0;
            res_cnt_q   <= '0;
            res_early_q <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                for (int i = 0; i < NUM_OUT; i++) cnt[i] <= '0;
                step_cnt    <= '0;
                drain_cnt   <= '0;
                arg_ptr     <= '0;
                best_idx    <= '0;
                best_cnt    <= '0;
                res_idx_q   <= '0;
                res_cnt_q   <= '0;
                res_early_q <= 1'b0;
            end
            if (count_en) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (bus.spk_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            if (bus.in_en) step_cnt <= step_cnt + STEP_W'(1);
            if (state == DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
            // A result only counts as early when the step budget did not also run out this cycle.
            if ((state == FETCH) && early_exit && !last_step && !bus.abort) res_early_q <= 1'b1;
            if ((state == ARGMAX) && !bus.abort) begin
                arg_ptr <= arg_ptr + IDX_W'(1);
                if (arg_gt) begin
                    best_idx <= arg_ptr;
                    best_cnt <= cnt[arg_ptr];
                end
                if (last_arg) begin
                    res_idx_q <= arg_gt ? arg_ptr : best_idx;
                    res_cnt_q <= arg_gt ? cnt[arg_ptr] : best_cnt;
                end
            end
        end
    end
endmodule
